// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, with stall, redirect/flush and end-of-memory halt.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] ins_in,
  output logic [15:0] pc_out,
  output logic [15:0] ifid_ins,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  // First byte address outside instruction memory; 17 bits so 65536 is representable.
  localparam logic [16:0] LIMIT = 17'(MEM_WORDS * 4);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] ins_nxt, ifpc_nxt, count_nxt;
  logic        valid_nxt;
  logic [15:0] pc_plus4;
  logic [15:0] target;

  assign pc_plus4 = pc + 16'd4;
  assign target   = redirect_pc & 16'hFFFC;

  // Next-state and next-register values; priority redirect > stall > state action.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ins_nxt   = ifid_ins;
    ifpc_nxt  = ifid_pc;
    valid_nxt = ifid_valid;
    count_nxt = fetch_count;
    if (redirect) begin
      pc_nxt    = target;
      ins_nxt   = 16'h0000;
      valid_nxt = 1'b0;
      state_nxt = ({1'b0, target} >= LIMIT) ? HALT : RUN;
    end else if (stall) begin
      state_nxt = state;
    end else begin
      case (state)
        RUN: begin
          ins_nxt   = ins_in;
          ifpc_nxt  = pc_plus4;
          valid_nxt = 1'b1;
          pc_nxt    = pc_plus4;
          if (fetch_count != 16'hFFFF) count_nxt = fetch_count + 16'd1;
          // The last word is still issued on the edge that enters HALT.
          if ({1'b0, pc_plus4} >= LIMIT) state_nxt = HALT;
        end
        HALT: begin
          ins_nxt   = 16'h0000;
          valid_nxt = 1'b0;
        end
        default: state_nxt = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      ifid_ins    <= 16'h0000;
      ifid_pc     <= 16'h0000;
      ifid_valid  <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ifid_ins    <= ins_nxt;
      ifid_pc     <= ifpc_nxt;
      ifid_valid  <= valid_nxt;
      fetch_count <= count_nxt;
    end
  end

  assign pc_out = pc;
  assign halted = (state == HALT);

endmodule
